// File: rtl/sipo_word_assembler.sv
// ----------------------------------------------------------------------------
// sipo_word_assembler
//
// Serial-in, parallel-out word assembler with a double-buffered output.
// Single-bit samples are shifted into a WIDTH-bit shift register. A completed
// word moves into a holding register that is presented on a valid/ready
// handshake. The shift register keeps filling while the held word waits.
// If a word completes while the holding register is occupied and not being
// consumed, that word is dropped and a sticky overrun flag is raised.
//
// Optional feature (macro SIPO_PARITY_CHECK_EN):
//   Each frame carries one trailing even-parity bit after the WIDTH data bits.
//   A frame that fails parity is dropped, and parity_err pulses for one cycle.
//   Without the macro, parity_err is tied to 0.
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   MSB_FIRST  1: first received bit ends up in word_out[WIDTH-1]
//              0: first received bit ends up in word_out[0]
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   bit_in      serial data bit, sampled when bit_valid=1
//   bit_valid   qualifies bit_in for one cycle
//   word_ready  downstream accepts word_out this cycle
//   clr_ovr     synchronous clear of overrun
//   word_out    assembled word (holding register)
//   word_valid  word_out holds an unconsumed word
//   overrun     sticky: a completed word was dropped
//   busy        a partial frame is in the shift register
//   parity_err  one-cycle pulse on a parity-failed frame (0 without the macro)
// ----------------------------------------------------------------------------
module sipo_word_assembler #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             word_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun,
    output logic             busy,
    output logic             parity_err
);

`ifdef SIPO_PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    state_t           r_state;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_ovr;

    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_candidate;
    logic             w_shift_en;
    logic             w_parity_ok;
    logic             w_complete;
    logic             w_accept;

    // Shift direction decides where the first bit finally lands.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_shift_next = r_shift;
        if (MSB_FIRST)
            w_shift_next = {r_shift[WIDTH-2:0], bit_in};
        else
            w_shift_next = {bit_in, r_shift[WIDTH-1:1]};
    end

`ifdef SIPO_PARITY_CHECK_EN
    // The parity bit arrives when the shift register already holds all data
    // bits; it is checked but never shifted in.
    assign w_candidate = r_shift;
    assign w_parity_ok = ~(^r_shift ^ bit_in);
    assign w_shift_en  = bit_valid && (r_cnt != CW'(WIDTH));
`else
    // The completing bit is merged in on the same edge it is sampled.
    assign w_candidate = w_shift_next;
    assign w_parity_ok = 1'b1;
    assign w_shift_en  = bit_valid;
`endif

    assign w_complete = bit_valid && (r_cnt == CW'(FRAME - 1));
    assign w_accept   = w_complete && w_parity_ok;

    // Shift register and frame bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            if (w_shift_en)
                r_shift <= w_shift_next;
            if (bit_valid)
                r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
        end
    end

    // Output buffer FSM with registered word, valid and overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the holding register is reset too, so word_out reads 0
            // until the first word rather than leaking pre-reset contents.
            r_state <= ST_EMPTY;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            // A later overrun set in this block overrides the clear.
            if (clr_ovr)
                r_ovr <= 1'b0;

            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_word  <= w_candidate;
                        r_valid <= 1'b1;
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        if (word_ready)
                            r_word <= w_candidate;  // seamless reload
                        else
                            r_ovr  <= 1'b1;         // candidate dropped
                    end else if (word_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    logic r_parity_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_parity_err <= 1'b0;
        else
            r_parity_err <= w_complete && !w_parity_ok;
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign overrun    = r_ovr;
    assign busy       = (r_cnt != '0);

endmodule

// File: doc/sipo_word_assembler.md
Name: sipo_word_assembler

Overview:
- Serial-in, parallel-out front end that collects single-bit samples into a WIDTH-bit word for the downstream WIDTH-bit D-input register stage.
- Double-buffered: the shift register keeps filling while the assembled word waits in a holding register.
- Presents words on a valid/ready handshake, with a sticky overrun flag.

Parameters:
- WIDTH, 4, data word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first received bit lands in word_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for one clk cycle.
- word_ready  input  1  downstream accepts word_out this cycle.
- clr_ovr  input  1  synchronous clear of overrun.
- word_out  output  WIDTH  assembled word (holding register).
- word_valid  output  1  word_out holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.
- busy  output  1  partial word present in the shift register (bit count != 0).
- parity_err  output  1  see Optional Feature.

Behaviour:
- Reset (async, rst=1): shift register, bit counter, word_out, word_valid, overrun and parity_err are all 0. Asserting rst mid-word discards the partial word. Resume on the first clk edge after rst deasserts.
- Bit counter: width $clog2(WIDTH+1).
  - Increments on each clk edge with bit_valid=1.
  - Cycles with bit_valid=0 do not advance the counter or shift the register.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
- Completion: the edge that samples the WIDTH-th bit is the completion edge.
  - Counter wraps to 0 on that edge.
  - The assembled word (including that bit) is the candidate for transfer on the same edge.
- Output buffer FSM, two states:
  - EMPTY (word_valid=0):
    - On completion: word_out <= candidate, go to FULL.
    - Latency: word_valid=1 in the cycle after the last bit is sampled.
  - FULL (word_valid=1):
    - Handshake occurs when word_valid=1 and word_ready=1 at a clk edge.
    - Handshake and no completion: go to EMPTY.
    - Completion and handshake on the same edge: load the candidate, stay FULL; word_valid remains 1 with no gap.
    - Completion without handshake: candidate dropped, word_out unchanged, overrun <= 1, stay FULL.
- Handshake rules:
  - word_out is stable while word_valid=1 and word_ready=0.
  - word_ready is ignored while word_valid=0.
- overrun: once set, holds until clr_ovr=1 or rst.
  - If clr_ovr and a new overrun event occur on the same edge, the set wins; overrun=1.
- busy = (bit counter != 0).
- Back-to-back bits: bit_valid high every cycle is supported. Throughput is one word per WIDTH cycles when word_ready is held at 1.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Each frame is WIDTH data bits plus one trailing even-parity bit; the counter runs to WIDTH+1.
  - Completion is the edge that samples the parity bit. The parity bit is not stored in word_out.
  - Parity mismatch (XOR of data bits and parity bit is 1): word dropped, the output buffer FSM is unaffected, and parity_err pulses high for exactly one cycle after the completion edge.
  - A parity-failed word never sets overrun.
- Undefined:
  - Frame is WIDTH bits.
  - parity_err is a constant 0; the port is always present.

Test Plan (WIDTH=4, MSB_FIRST=1 unless stated):
1. Assert rst after 2 of 4 bits, then release and send 1,0,1,1 -> during rst all outputs are 0; afterwards word_out=4'b1011 and no stale bits remain.
2. bit_valid=1 for 4 consecutive cycles with bits 1,0,1,1 and word_ready=1 -> word_valid=1 for exactly one cycle, the cycle after the 4th bit, with word_out=4'b1011; busy=1 after bits 1-3 and 0 after the 4th.
3. Same bits with bit_valid=0 gaps of 3 cycles between bits -> identical word_out=4'b1011; the counter holds during gaps.
4. word_ready=0; send 1,0,1,1 then 0,1,1,0 -> word_out stays 4'b1011 and overrun=1 after the 2nd completion. Then clr_ovr=1 for one cycle -> overrun=0, word_out still 4'b1011.
5. Hold 4'b1011 in FULL; assert word_ready on the same edge that completes 0,1,1,0 -> word_out=4'b0110, word_valid stays 1 throughout, overrun=0.
6. MSB_FIRST=0, bits 1,0,1,1 -> word_out=4'b1101. With SIPO_PARITY_CHECK_EN, frame 1,0,1,1 + parity 0 -> parity_err pulses one cycle and word_valid stays 0; frame 1,0,1,1 + parity 1 -> word accepted, word_out=4'b1101.
